zigzag_scan_pp: RTL and testbench
=================================

# zigzag_scan_pp

Parametrised N×N block reorderer for the transform/entropy path. It accepts coefficients in raster order and emits each block in zigzag order, or in transposed (column-major) order. Two ping-pong banks let block k+1 be written while block k is read out. Both input and output use valid/ready handshakes, so the block sits between the quantiser and the run-length coder with backpressure on both sides.

## Interface
Parameters:
- DW, default 10: coefficient width in bits.
- N, default 8: block side. Must be a power of two, 2..32. Derived LOGN = log2(N), AW = 2·LOGN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accept. Reset value 1.
- in_data  in  DW  coefficient, raster order (row-major).
- scan_mode  in  1  0 = zigzag, 1 = transpose. Sampled with the first accepted sample of each block.
- out_valid  out  1  output valid. Reset value 0.
- out_ready  in  1  downstream accept.
- out_data  out  DW  reordered coefficient. Reset value 0.
- out_last  out  1  high with the N²-th output of a block. Reset value 0.
- bank_full  out  2  bank occupancy flags, for debug. Reset value 2'b00.

## Operation
- Two banks of N² × DW each. Bank index for the write pointer (wbank) and read pointer (rbank) resets to 0. Memory contents are not reset.
- Writer:
  - A transfer occurs when in_valid && in_ready. The sample is stored at raster address wcnt in bank wbank, and wcnt (AW bits) increments.
  - scan_mode is captured into mode[wbank] when wcnt==0.
  - At wcnt==N²−1 the transfer sets bank_full[wbank], wraps wcnt to 0, and toggles wbank.
  - in_ready = !bank_full[wbank].
- Reader FSM states: IDLE, RUN.
  - IDLE → RUN when bank_full[rbank]. On entry, set r=c=0 and dir=UP.
  - In RUN, each read address is r·N+c, taken from bank rbank.
  - RUN → IDLE after the N²-th element is handed to the output stage. On that exit, clear bank_full[rbank] and toggle rbank.
- Zigzag step (mode 0):
  - UP direction:
    - If c==N−1: r+1, set dir DN.
    - Else if r==0: c+1, set dir DN.
    - Else: r−1, c+1.
  - DN direction:
    - If r==N−1: c+1, set dir UP.
    - Else if c==0: r+1, set dir UP.
    - Else: r+1, c−1.
- Transpose step (mode 1): r increments. When r==N−1, r wraps to 0 and c increments.
- Order is generated arithmetically. No lookup table.
- Output stage:
  - Bank reads are synchronous (1 cycle), so the output path holds a 2-entry skid buffer.
  - The reader advances only while the buffer has space.
  - No sample is lost or duplicated under any out_ready pattern.
- Simultaneous events:
  - Set and clear of the same bank_full bit in one cycle cannot occur, because the writer only targets a non-full bank.
  - The writer may fill one bank while the reader drains the other in the same cycle.
- Reset mid-block: all pointers, FSM, flags and outputs return to reset values immediately. The partial block is discarded.

## Timing
- Latency: the final write of a block is accepted at edge t. With out_ready high, the first out_valid is at edge t+2.
- Throughput: one sample per cycle on each side. With out_ready held high, continuous input never sees in_ready low.
- out_data, out_last and out_valid are registered. They hold steady while out_valid && !out_ready.
- in_ready is a register-derived combinational term, with no combinational path from out_ready.

## Structure
- Shared package holds:
  - the scan-mode constants SCAN_ZIGZAG = 1'b0 and SCAN_TRANSPOSE = 1'b1;
  - the direction encoding DIR_UP/DIR_DN;
  - the reader state typedef (IDLE/RUN).
- One sub-module, zz_addr_gen: holds r, c and dir, with inputs start, step and mode, and outputs addr and last.
- The banks are inferred dual-port arrays: one write port and one read port per bank.

## Test plan
- Zigzag, N=8, DW=10, in_data = 0..63, out_ready=1 → out_data sequence is 0,1,8,16,9,2,3,10,17,24,… ending 55,62,63. out_last is high only with 63. First out_valid is 2 cycles after the last write.
- Transpose mode, same stimulus → output is 0,8,16,…,56,1,9,…,63.
- Ping-pong: 3 back-to-back blocks, out_ready=1 → in_ready stays 1 throughout and all 192 outputs are in order. Each block uses the mode latched at its own first sample.
- Backpressure: out_ready=0 while 2 blocks are written → in_ready drops after the 128th sample and bank_full=2'b11. Then toggle out_ready 1/0 randomly → outputs are complete and unduplicated, and in_ready rises after the first block drains.
- Reset mid-operation: assert rst_n low after 30 writes and 5 reads → in_ready=1, out_valid=0, bank_full=0. A fresh block afterwards produces the correct zigzag order.
- N=4 build → output is 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.

Source files
------------

// File: rtl/zigzag_scan_pp_pkg.sv
// rtl/zigzag_scan_pp_pkg.sv - shared constants and types for the zigzag/transpose block reorderer
package zigzag_scan_pp_pkg;

  localparam logic SCAN_ZIGZAG    = 1'b0;
  localparam logic SCAN_TRANSPOSE = 1'b1;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/zigzag_scan_pp_addr_gen.sv
// rtl/zigzag_scan_pp_addr_gen.sv - arithmetic row/column walker producing zigzag or column-major read addresses
module zz_addr_gen
  import zigzag_scan_pp_pkg::*;
#(
  parameter int N    = 8,
  parameter int LOGN = $clog2(N),
  parameter int AW   = 2 * LOGN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic          mode,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [LOGN-1:0] MAXI = LOGN'(N - 1);
  localparam logic [LOGN-1:0] ONE  = LOGN'(1);

  logic [LOGN-1:0] r;
  logic [LOGN-1:0] c;
  dir_t            dir;

  // start wins over step so the final element of a block rearms the walker at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r   <= '0;
      c   <= '0;
      dir <= DIR_UP;
    end else if (start) begin
      r   <= '0;
      c   <= '0;
      dir <= DIR_UP;
    end else if (step) begin
      if (mode == SCAN_TRANSPOSE) begin
        if (r == MAXI) begin
          r <= '0;
          c <= c + ONE;
        end else begin
          r <= r + ONE;
        end
      end else if (dir == DIR_UP) begin
        if (c == MAXI) begin
          r   <= r + ONE;
          dir <= DIR_DN;
        end else if (r == '0) begin
          c   <= c + ONE;
          dir <= DIR_DN;
        end else begin
          r <= r - ONE;
          c <= c + ONE;
        end
      end else begin
        if (r == MAXI) begin
          c   <= c + ONE;
          dir <= DIR_UP;
        end else if (c == '0) begin
          r   <= r + ONE;
          dir <= DIR_UP;
        end else begin
          r <= r + ONE;
          c <= c - ONE;
        end
      end
    end
  end

  // N is a power of two, so r*N+c is a plain concatenation
  assign addr = {r, c};
  assign last = (r == MAXI) && (c == MAXI);

endmodule

// File: rtl/zigzag_scan_pp.sv
// rtl/zigzag_scan_pp.sv - ping-pong N×N block reorderer, raster in, zigzag or transposed out
module zigzag_scan_pp
  import zigzag_scan_pp_pkg::*;
#(
  parameter int DW = 10,
  parameter int N  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          scan_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    bank_full
);

  localparam int LOGN  = $clog2(N);
  localparam int AW    = 2 * LOGN;
  localparam int DEPTH = N * N;
  localparam logic [AW-1:0] A_ONE = AW'(1);

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] q0, q1;

  logic [AW-1:0] wcnt;
  logic          wbank;
  logic [1:0]    mode_r;
  logic          wr, wr_last;

  rd_state_t     state;
  logic          rbank;
  logic          rd_valid, rd_last, rd_bank;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] raddr;
  logic          gen_last;
  logic          issue, done, space, pop;
  logic [1:0]    occ;

  logic          skid_valid, skid_last;
  logic [DW-1:0] skid_data;

  assign in_ready = !bank_full[wbank];
  assign wr       = in_valid && in_ready;
  assign wr_last  = wr && (&wcnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      mode_r    <= '0;
      bank_full <= 2'b00;
    end else begin
      if (wr) begin
        wcnt <= wcnt + A_ONE;
        if (wcnt == '0) mode_r[wbank] <= scan_mode;
        if (&wcnt) wbank <= ~wbank;
      end
      bank_full <= (bank_full | (wr_last ? (2'b01 << wbank) : 2'b00))
                 & ~(done ? (2'b01 << rbank) : 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !wbank) mem0[wcnt] <= in_data;
    if (issue && !rbank) q0 <= mem0[raddr];
  end

  always_ff @(posedge clk) begin
    if (wr && wbank) mem1[wcnt] <= in_data;
    if (issue && rbank) q1 <= mem1[raddr];
  end

  // Occupancy counts the read in flight, so a new read is only issued when it is guaranteed a slot
  assign pop   = out_valid && out_ready;
  assign occ   = 2'(out_valid) + 2'(skid_valid) + 2'(rd_valid);
  assign space = (occ - {1'b0, pop}) < 2'd2;
  assign issue = space && ((state == RUN) || bank_full[rbank]);
  assign done  = issue && gen_last;

  zz_addr_gen #(
    .N   (N),
    .LOGN(LOGN),
    .AW  (AW)
  ) u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .start(done),
    .step (issue),
    .mode (mode_r[rbank]),
    .addr (raddr),
    .last (gen_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rbank    <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_bank  <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_last <= gen_last;
        rd_bank <= rbank;
      end
      case (state)
        IDLE: if (issue) state <= RUN;
        RUN: begin
          if (done) begin
            state <= IDLE;
            rbank <= ~rbank;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data = rd_bank ? q1 : q0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= rd_valid;
        skid_data  <= rd_data;
        skid_last  <= rd_last;
      end else begin
        out_valid <= rd_valid;
        out_last  <= rd_valid && rd_last;
        if (rd_valid) out_data <= rd_data;
      end
    end else if (rd_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= rd_data;
      skid_last  <= rd_last;
    end
  end

endmodule

// File: tb/tb_zigzag_scan_pp.sv
// tb/tb_zigzag_scan_pp.sv - self-checking bench for zigzag_scan_pp (N=8 main instance, N=4 side instance)
module tb_zigzag_scan_pp;

  localparam int DW = 10;
  localparam int N  = 8;
  localparam int NN = N * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, scan_mode;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic [1:0]    bank_full;

  logic          in4_valid, in4_ready, scan4;
  logic [DW-1:0] in4_data;
  logic          out4_valid, out4_ready, out4_last;
  logic [DW-1:0] out4_data;
  logic [1:0]    bank_full4;

  zigzag_scan_pp #(.DW(DW), .N(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .scan_mode(scan_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .bank_full(bank_full)
  );

  zigzag_scan_pp #(.DW(DW), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data), .scan_mode(scan4),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data), .out_last(out4_last),
    .bank_full(bank_full4)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          m;
  } stim_t;

  typedef struct {
    bit mode;
    int idx;
    int d;
    bit l;
  } vec_t;

  vec_t tbl [16] = '{
    '{0, 0, 0, 0},  '{0, 1, 1, 0},  '{0, 2, 8, 0},   '{0, 3, 16, 0},
    '{0, 4, 9, 0},  '{0, 5, 2, 0},  '{0, 9, 24, 0},  '{0, 61, 55, 0},
    '{0, 62, 62, 0}, '{0, 63, 63, 1}, '{1, 0, 0, 0}, '{1, 1, 8, 0},
    '{1, 7, 56, 0}, '{1, 8, 1, 0},  '{1, 62, 55, 0}, '{1, 63, 63, 1}
  };

  int exp4 [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  stim_t         stim_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic          exp_l_q[$];
  logic [DW-1:0] log_d[$];
  logic          log_l[$];

  int vectors = 0, miscompares = 0;
  int ready_pct = 100, gap_pct = 0;
  int wr_cnt = 0, out_cnt = 0, stall_cnt = 0, cyc = 0;
  int last_wr_cyc = -1, first_ov_cyc = -1;
  bit lat_arm = 0, held = 0;
  logic [DW-1:0] held_d;
  logic held_l;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference ordering: walk anti-diagonals, even diagonals bottom-to-top, odd ones top-to-bottom
  function automatic int src_idx(input int n, input bit mode, input int k);
    int idx = 0;
    if (mode) return (k % n) * n + k / n;
    for (int d = 0; d <= 2 * n - 2; d++) begin
      int lo = (d - n + 1 > 0) ? d - n + 1 : 0;
      int hi = (d < n - 1) ? d : n - 1;
      for (int t = 0; t <= hi - lo; t++) begin
        int r = (d % 2 == 0) ? hi - t : lo + t;
        if (idx == k) return r * n + (d - r);
        idx++;
      end
    end
    return -1;
  endfunction

  task automatic push_block(input bit mode, input bit rnd, input int nsamp);
    logic [DW-1:0] blk [NN];
    stim_t s;
    for (int k = 0; k < NN; k++) blk[k] = rnd ? DW'($urandom) : DW'(k);
    for (int k = 0; k < nsamp; k++) begin
      s.d = blk[k];
      s.m = (k == 0) ? mode : 1'($urandom);
      stim_q.push_back(s);
    end
    if (nsamp == NN)
      for (int k = 0; k < NN; k++) begin
        exp_d_q.push_back(blk[src_idx(N, mode, k)]);
        exp_l_q.push_back(k == NN - 1);
      end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4000 && (stim_q.size() != 0 || exp_d_q.size() != 0); i++) @(negedge clk);
    check(name, exp_d_q.size() + stim_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n || stim_q.size() == 0 || $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
    end else begin
      in_valid  = 1'b1;
      in_data   = stim_q[0].d;
      scan_mode = stim_q[0].m;
      if (in_ready) begin
        stim_q.delete(0);
        wr_cnt++;
        if (stim_q.size() == 0) last_wr_cyc = cyc + 1;
      end else begin
        stall_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held      = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_d);
        check("hold_last", out_last, held_l);
      end
      if (out_valid && lat_arm) begin
        first_ov_cyc = cyc;
        lat_arm = 0;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        out_cnt++;
        log_d.push_back(out_data);
        log_l.push_back(out_last);
        if (exp_d_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_data", out_data, exp_d_q[0]);
          check("out_last", out_last, exp_l_q[0]);
          exp_d_q.delete(0);
          exp_l_q.delete(0);
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int wr0, out0, nlast;
    int got4[$];
    bit last4[$];

    rst_n = 0; in_valid = 0; in_data = '0; scan_mode = 0; out_ready = 0;
    in4_valid = 0; in4_data = '0; scan4 = 0; out4_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_bank_full", bank_full, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    for (int m = 0; m < 2; m++) begin
      log_d.delete(); log_l.delete();
      lat_arm = 1;
      push_block(m[0], 0, NN);
      wait_drain(m ? "tr_drain" : "zz_drain");
      check("latency", first_ov_cyc - last_wr_cyc, 2);
      check("block_len", log_d.size(), NN);
      nlast = 0;
      foreach (log_l[i]) nlast += log_l[i];
      check("last_count", nlast, 1);
      for (int i = 0; i < 16; i++)
        if (tbl[i].mode == m[0]) begin
          check("tbl_data", (tbl[i].idx < log_d.size()) ? 64'(log_d[tbl[i].idx]) : 'x, tbl[i].d);
          check("tbl_last", (tbl[i].idx < log_l.size()) ? 64'(log_l[tbl[i].idx]) : 'x, tbl[i].l);
        end
    end

    stall_cnt = 0; out0 = out_cnt;
    push_block(0, 1, NN); push_block(1, 1, NN); push_block(0, 1, NN);
    wait_drain("pp_drain");
    check("pp_stalls", stall_cnt, 0);
    check("pp_outputs", out_cnt - out0, 3 * NN);

    ready_pct = 0; wr0 = wr_cnt; out0 = out_cnt;
    push_block(1'($urandom), 1, NN); push_block(1'($urandom), 1, NN);
    for (int i = 0; i < 400 && wr_cnt - wr0 < 2 * NN; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("bp_writes", wr_cnt - wr0, 2 * NN);
    check("bp_in_ready", in_ready, 0);
    check("bp_bank_full", bank_full, 2'b11);
    push_block(1'($urandom), 1, NN);
    repeat (10) @(negedge clk);
    check("bp_blocked", wr_cnt - wr0, 2 * NN);
    ready_pct = 50;
    for (int i = 0; i < 2000 && !in_ready; i++) @(negedge clk);
    check("bp_rise_outputs", ((out_cnt - out0) >= NN - 3) && ((out_cnt - out0) <= NN), 1);
    wait_drain("bp_drain");
    check("bp_outputs", out_cnt - out0, 3 * NN);

    ready_pct = 0; wr0 = wr_cnt;
    push_block(0, 1, NN); push_block(1, 1, 30);
    for (int i = 0; i < 400 && wr_cnt - wr0 < NN + 30; i++) @(negedge clk);
    check("rm_writes", wr_cnt - wr0, NN + 30);
    ready_pct = 100; out0 = out_cnt;
    for (int i = 0; i < 100 && out_cnt - out0 < 5; i++) @(negedge clk);
    #2;
    stim_q.delete(); exp_d_q.delete(); exp_l_q.delete();
    in_valid = 0;
    rst_n = 0;
    #1;
    check("rm_in_ready", in_ready, 1);
    check("rm_out_valid", out_valid, 0);
    check("rm_bank_full", bank_full, 0);
    check("rm_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1;
    out0 = out_cnt;
    push_block(0, 1, NN);
    wait_drain("rm_drain");
    check("rm_outputs", out_cnt - out0, NN);

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in4_valid = 1; in4_data = DW'(k); scan4 = 0;
      check("n4_in_ready", in4_ready, 1);
    end
    @(negedge clk);
    in4_valid = 0;
    for (int i = 0; i < 100 && got4.size() < 16; i++) begin
      if (out4_valid) begin
        got4.push_back(int'(out4_data));
        last4.push_back(out4_last);
      end
      @(negedge clk);
    end
    check("n4_len", got4.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check("n4_data", (i < got4.size()) ? 64'(got4[i]) : 'x, exp4[i]);
      check("n4_last", (i < last4.size()) ? 64'(last4[i]) : 'x, i == 15);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
